// File: rtl/cell_update_queue.sv
// Cell-write FIFO that drains into matrix_display only during vertical blank, then commits once.
// Optional macro CELL_QUEUE_DROP_COUNT_EN adds a saturating drop_count output.
module cell_update_queue #(
    parameter int unsigned B_WIDTH    = 5,
    parameter int unsigned B_HEIGHT   = 4,
    parameter int unsigned B_VGA      = 4,
    parameter int unsigned B_S_HEIGHT = 10,
    parameter int unsigned S_HEIGHT   = 768,
    parameter int unsigned DEPTH      = 16,
    parameter int unsigned B_DEPTH    = 4
) (
    input  logic                  vclock,
    input  logic                  reset,
    input  logic                  wr_en,
    input  logic [B_WIDTH-1:0]    wr_x,
    input  logic [B_HEIGHT-1:0]   wr_y,
    input  logic [3*B_VGA-1:0]    wr_rgb,
    output logic                  wr_ready,
    input  logic [B_S_HEIGHT-1:0] vcount,
    output logic [B_WIDTH-1:0]    cell_x,
    output logic [B_HEIGHT-1:0]   cell_y,
    output logic [3*B_VGA-1:0]    cell_rgb,
    output logic                  cell_en,
    output logic                  update,
    output logic [B_DEPTH:0]      level,
    output logic                  overflow
`ifdef CELL_QUEUE_DROP_COUNT_EN
    ,
    output logic [7:0]            drop_count
`endif
);

    localparam int unsigned EW = B_WIDTH + B_HEIGHT + 3 * B_VGA;
    localparam logic [B_DEPTH:0]   LEVEL_ONE  = (B_DEPTH + 1)'(1);
    localparam logic [B_DEPTH:0]   LEVEL_FULL = (B_DEPTH + 1)'(DEPTH);
    localparam logic [B_DEPTH-1:0] PTR_ONE    = B_DEPTH'(1);

    typedef enum logic [1:0] {StIdle, StDrain, StCommit, StHold} state_e;

    state_e                state_q, state_d;
    logic [EW-1:0]         mem_q [DEPTH];
    logic [B_DEPTH-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [B_DEPTH:0]      level_q, level_d;
    logic [B_WIDTH-1:0]    cell_x_q, cell_x_d;
    logic [B_HEIGHT-1:0]   cell_y_q, cell_y_d;
    logic [3*B_VGA-1:0]    cell_rgb_q, cell_rgb_d;
    logic                  cell_en_q, cell_en_d;
    logic                  update_q, update_d;
    logic                  overflow_q, overflow_d;
    logic                  in_blank, full, push, pop;

    assign in_blank = (vcount >= B_S_HEIGHT'(S_HEIGHT));
    assign full     = (level_q == LEVEL_FULL);
    // A full FIFO refuses a push even when a pop frees a slot this same cycle.
    assign push     = wr_en && !full;

    always_comb begin
        state_d    = state_q;
        pop        = 1'b0;
        update_d   = 1'b0;
        unique case (state_q)
            StIdle:   if (in_blank && level_q != '0) state_d = StDrain;
            StDrain: begin
                if (in_blank && level_q != '0) begin
                    pop = 1'b1;
                end else begin
                    state_d  = StCommit;
                    update_d = 1'b1;
                end
            end
            StCommit: state_d = StHold;
            StHold:   if (!in_blank) state_d = StIdle;
        endcase
    end

    always_comb begin
        wr_ptr_d   = push ? wr_ptr_q + PTR_ONE : wr_ptr_q;
        rd_ptr_d   = pop ? rd_ptr_q + PTR_ONE : rd_ptr_q;
        level_d    = level_q;
        if (push && !pop) level_d = level_q + LEVEL_ONE;
        if (pop && !push) level_d = level_q - LEVEL_ONE;
        cell_en_d  = pop;
        cell_x_d   = cell_x_q;
        cell_y_d   = cell_y_q;
        cell_rgb_d = cell_rgb_q;
        if (pop) {cell_x_d, cell_y_d, cell_rgb_d} = mem_q[rd_ptr_q];
        overflow_d = overflow_q | (wr_en && full);
    end

    always_ff @(posedge vclock) begin
        if (push) mem_q[wr_ptr_q] <= {wr_x, wr_y, wr_rgb};
    end

    always_ff @(posedge vclock or negedge reset) begin
        if (!reset) begin
            state_q    <= StIdle;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            level_q    <= '0;
            cell_x_q   <= '0;
            cell_y_q   <= '0;
            cell_rgb_q <= '0;
            cell_en_q  <= 1'b0;
            update_q   <= 1'b0;
            overflow_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            level_q    <= level_d;
            cell_x_q   <= cell_x_d;
            cell_y_q   <= cell_y_d;
            cell_rgb_q <= cell_rgb_d;
            cell_en_q  <= cell_en_d;
            update_q   <= update_d;
            overflow_q <= overflow_d;
        end
    end

`ifdef CELL_QUEUE_DROP_COUNT_EN
    logic [7:0] drop_count_q, drop_count_d;

    always_comb begin
        drop_count_d = drop_count_q;
        if (wr_en && full && drop_count_q != 8'hFF) drop_count_d = drop_count_q + 8'd1;
    end

    always_ff @(posedge vclock or negedge reset) begin
        if (!reset) drop_count_q <= 8'd0;
        else        drop_count_q <= drop_count_d;
    end

    assign drop_count = drop_count_q;
`endif

    assign wr_ready = !full;
    assign level    = level_q;
    assign cell_x   = cell_x_q;
    assign cell_y   = cell_y_q;
    assign cell_rgb = cell_rgb_q;
    assign cell_en  = cell_en_q;
    assign update   = update_q;
    assign overflow = overflow_q;

endmodule

// File: tb/tb_cell_update_queue.sv
// Self-checking bench for cell_update_queue: FIFO-order scoreboard plus frame-level commit rules.
// Builds with or without CELL_QUEUE_DROP_COUNT_EN.
module tb_cell_update_queue;

    localparam int unsigned DEPTH    = 16;
    localparam int unsigned S_HEIGHT = 768;

    logic        vclock, reset, wr_en, wr_ready, cell_en, update, overflow;
    logic [4:0]  wr_x, cell_x, level;
    logic [3:0]  wr_y, cell_y;
    logic [11:0] wr_rgb, cell_rgb;
    logic [9:0]  vcount;
`ifdef CELL_QUEUE_DROP_COUNT_EN
    logic [7:0]  drop_count;
`endif

    cell_update_queue dut (
        .vclock   (vclock),
        .reset    (reset),
        .wr_en    (wr_en),
        .wr_x     (wr_x),
        .wr_y     (wr_y),
        .wr_rgb   (wr_rgb),
        .wr_ready (wr_ready),
        .vcount   (vcount),
        .cell_x   (cell_x),
        .cell_y   (cell_y),
        .cell_rgb (cell_rgb),
        .cell_en  (cell_en),
        .update   (update),
        .level    (level),
        .overflow (overflow)
`ifdef CELL_QUEUE_DROP_COUNT_EN
        ,
        .drop_count (drop_count)
`endif
    );

    initial vclock = 1'b0;
    always #5 vclock = ~vclock;

    int          checks, failures;
    logic [20:0] sb[$];
    logic [20:0] last_m;
    bit          ovf_m, prev_en, committed;
    int          drops_m, en_cnt, upd_cnt, max_level;

    task automatic model_reset();
        sb.delete();
        last_m    = '0;
        ovf_m     = 1'b0;
        prev_en   = 1'b0;
        committed = 1'b0;
        drops_m   = 0;
    endtask

    // One clock: drive, account accepted push at the edge, check everything at the negedge.
    task automatic cycle(input bit push, input logic [20:0] data, input logic [9:0] vc);
        bit          accept;
        logic [20:0] got, exp;
        wr_en = push;
        {wr_x, wr_y, wr_rgb} = data;
        vcount = vc;
        accept = push && (sb.size() < DEPTH);
        if (push && !accept) begin
            ovf_m = 1'b1;
            if (drops_m < 255) drops_m++;
        end
        @(posedge vclock);
        if (accept) sb.push_back(data);
        @(negedge vclock);
        got = {cell_x, cell_y, cell_rgb};
        checks++;
        if (update !== (prev_en && cell_en !== 1'b1)) begin
            failures++;
            $display("FAIL update_timing: got %b required %b at %0t", update,
                     prev_en && cell_en !== 1'b1, $time);
        end
        checks++;
        if (cell_en === 1'b1) begin
            en_cnt++;
            if (sb.size() == 0 || committed) begin
                failures++;
                $display("FAIL stray_cell_en: got strobe, queued=%0d committed=%0b required none",
                         sb.size(), committed);
            end else begin
                exp = sb.pop_front();
                last_m = exp;
                if (got !== exp) begin
                    failures++;
                    $display("FAIL cell_data: got %h required %h", got, exp);
                end
            end
        end else if (got !== last_m) begin
            failures++;
            $display("FAIL cell_hold: got %h required %h", got, last_m);
        end
        if (update === 1'b1) begin
            upd_cnt++;
            committed = 1'b1;
        end
        if (vc < S_HEIGHT) committed = 1'b0;
        prev_en = (cell_en === 1'b1);
        if (int'(level) > max_level) max_level = int'(level);
        checks++;
        if (level !== 5'(sb.size())) begin
            failures++;
            $display("FAIL level: got %0d required %0d", level, sb.size());
        end
        checks++;
        if (wr_ready !== (sb.size() < DEPTH)) begin
            failures++;
            $display("FAIL wr_ready: got %b required %b", wr_ready, sb.size() < DEPTH);
        end
        checks++;
        if (overflow !== ovf_m) begin
            failures++;
            $display("FAIL overflow: got %b required %b", overflow, ovf_m);
        end
`ifdef CELL_QUEUE_DROP_COUNT_EN
        checks++;
        if (drop_count !== 8'(drops_m)) begin
            failures++;
            $display("FAIL drop_count: got %0d required %0d", drop_count, drops_m);
        end
`endif
    endtask

    // n cycles in active video or blank; pushes at pct percent, none in the last `guard` cycles.
    task automatic run_phase(input int n, input bit blank, input int pct, input int guard);
        logic [9:0] vc;
        bit         p;
        for (int i = 0; i < n; i++) begin
            vc = blank ? 10'(S_HEIGHT + $urandom_range(0, 255)) : 10'($urandom_range(0, S_HEIGHT - 1));
            p  = (i < n - guard) && ($urandom_range(0, 99) < pct);
            cycle(p, 21'($urandom), vc);
        end
    endtask

    task automatic check_outputs_clear(input string tag);
        checks++;
        if ({cell_x, cell_y, cell_rgb, cell_en, update, overflow, level} !== '0) begin
            failures++;
            $display("FAIL %s_outputs: got x=%h y=%h rgb=%h en=%b upd=%b ovf=%b lvl=%0d required all 0",
                     tag, cell_x, cell_y, cell_rgb, cell_en, update, overflow, level);
        end
        checks++;
        if (wr_ready !== 1'b1) begin
            failures++;
            $display("FAIL %s_wr_ready: got %b required 1", tag, wr_ready);
        end
`ifdef CELL_QUEUE_DROP_COUNT_EN
        checks++;
        if (drop_count !== 8'd0) begin
            failures++;
            $display("FAIL %s_drop_count: got %0d required 0", tag, drop_count);
        end
`endif
    endtask

    task automatic test_reset();
        reset = 1'b0;
        wr_en = 1'b0;
        {wr_x, wr_y, wr_rgb} = '0;
        vcount = 10'd0;
        #12;
        check_outputs_clear("reset");
        model_reset();
        @(negedge vclock);
        reset = 1'b1;
    endtask

    task automatic test_latency();
        en_cnt = 0;
        upd_cnt = 0;
        cycle(1'b1, {5'd3, 4'd2, 12'hF00}, 10'd100);
        checks++;
        if (level !== 5'd1 || cell_en !== 1'b0) begin
            failures++;
            $display("FAIL latency_push: got level=%0d en=%b required level=1 en=0", level, cell_en);
        end
        cycle(1'b0, '0, 10'd768);
        checks++;
        if (cell_en !== 1'b0) begin
            failures++;
            $display("FAIL latency_first_blank: got en=%b required 0", cell_en);
        end
        cycle(1'b0, '0, 10'd768);
        checks++;
        if (cell_en !== 1'b1 || cell_x !== 5'd3 || cell_y !== 4'd2 || cell_rgb !== 12'hF00) begin
            failures++;
            $display("FAIL latency_cell: got en=%b x=%0d y=%0d rgb=%h required 1 3 2 f00",
                     cell_en, cell_x, cell_y, cell_rgb);
        end
        cycle(1'b0, '0, 10'd768);
        checks++;
        if (update !== 1'b1 || level !== 5'd0) begin
            failures++;
            $display("FAIL latency_update: got upd=%b level=%0d required 1 0", update, level);
        end
        run_phase(4, 1'b1, 0, 0);
        run_phase(3, 1'b0, 0, 0);
    endtask

    task automatic test_overflow();
        for (int i = 0; i < 16; i++) cycle(1'b1, 21'($urandom), 10'd100);
        checks++;
        if (wr_ready !== 1'b0) begin
            failures++;
            $display("FAIL full_wr_ready: got %b required 0", wr_ready);
        end
        cycle(1'b1, 21'($urandom), 10'd100);
        checks++;
        if (overflow !== 1'b1 || level !== 5'd16) begin
            failures++;
            $display("FAIL overflow_push: got ovf=%b level=%0d required 1 16", overflow, level);
        end
`ifdef CELL_QUEUE_DROP_COUNT_EN
        checks++;
        if (drop_count !== 8'd1) begin
            failures++;
            $display("FAIL overflow_drop_count: got %0d required 1", drop_count);
        end
`endif
    endtask

    task automatic test_partial_drain();
        int n;
        en_cnt = 0;
        upd_cnt = 0;
        n = 0;
        while (en_cnt < 5 && n < 20) begin
            cycle(1'b0, '0, 10'd768);
            n++;
        end
        checks++;
        if (en_cnt != 5) begin
            failures++;
            $display("FAIL partial_wait: got %0d strobes in 20 cycles required 5", en_cnt);
        end
        run_phase(10, 1'b0, 0, 0);
        checks++;
        if (en_cnt != 5 || upd_cnt != 1 || level !== 5'd11) begin
            failures++;
            $display("FAIL partial_drain: got en=%0d upd=%0d level=%0d required 5 1 11",
                     en_cnt, upd_cnt, level);
        end
        en_cnt = 0;
        upd_cnt = 0;
        run_phase(20, 1'b1, 0, 0);
        checks++;
        if (en_cnt != 11 || upd_cnt != 1 || level !== 5'd0) begin
            failures++;
            $display("FAIL partial_rest: got en=%0d upd=%0d level=%0d required 11 1 0",
                     en_cnt, upd_cnt, level);
        end
        run_phase(3, 1'b0, 0, 0);
    endtask

    task automatic test_back_to_back();
        run_phase(4, 1'b0, 100, 0);
        max_level = 0;
        run_phase(20, 1'b1, 100, 0);
        checks++;
        if (max_level > 6 || max_level < 3) begin
            failures++;
            $display("FAIL concurrent_level: got max level %0d required 3..6", max_level);
        end
        run_phase(5, 1'b0, 0, 0);
        run_phase(30, 1'b1, 0, 0);
        checks++;
        if (sb.size() != 0 || level !== 5'd0) begin
            failures++;
            $display("FAIL concurrent_drain: got level=%0d left=%0d required 0 0", level, sb.size());
        end
        run_phase(3, 1'b0, 0, 0);
    endtask

    task automatic test_one_commit_per_frame();
        en_cnt = 0;
        upd_cnt = 0;
        run_phase(8, 1'b1, 0, 0);
        checks++;
        if (en_cnt != 0 || upd_cnt != 0) begin
            failures++;
            $display("FAIL empty_blank: got en=%0d upd=%0d required 0 0", en_cnt, upd_cnt);
        end
        run_phase(2, 1'b0, 100, 0);
        for (int i = 0; i < 12; i++) cycle(i >= 6 && i < 10, 21'($urandom), 10'd780);
        checks++;
        if (en_cnt != 2 || upd_cnt != 1 || level !== 5'd4) begin
            failures++;
            $display("FAIL single_commit: got en=%0d upd=%0d level=%0d required 2 1 4",
                     en_cnt, upd_cnt, level);
        end
        run_phase(3, 1'b0, 0, 0);
        run_phase(12, 1'b1, 0, 0);
        checks++;
        if (en_cnt != 6 || upd_cnt != 2) begin
            failures++;
            $display("FAIL next_frame_commit: got en=%0d upd=%0d required 6 2", en_cnt, upd_cnt);
        end
        run_phase(3, 1'b0, 0, 0);
    endtask

    task automatic test_reset_mid_drain();
        run_phase(8, 1'b0, 100, 0);
        en_cnt = 0;
        for (int i = 0; i < 4; i++) cycle(1'b0, '0, 10'd800);
        wr_en = 1'b0;
        #2;
        reset = 1'b0;
        #1;
        check_outputs_clear("mid_drain_reset");
        model_reset();
        @(negedge vclock);
        @(negedge vclock);
        reset = 1'b1;
        en_cnt = 0;
        upd_cnt = 0;
        run_phase(4, 1'b1, 0, 0);
        checks++;
        if (en_cnt != 0 || upd_cnt != 0) begin
            failures++;
            $display("FAIL post_reset_quiet: got en=%0d upd=%0d required 0 0", en_cnt, upd_cnt);
        end
        run_phase(4, 1'b0, 0, 0);
        run_phase(2, 1'b0, 100, 0);
        run_phase(8, 1'b1, 0, 0);
        checks++;
        if (en_cnt != 2 || upd_cnt != 1) begin
            failures++;
            $display("FAIL post_reset_drain: got en=%0d upd=%0d required 2 1", en_cnt, upd_cnt);
        end
        run_phase(3, 1'b0, 0, 0);
    endtask

    task automatic test_random();
        int u0;
        for (int f = 0; f < 10; f++) begin
            run_phase($urandom_range(5, 30), 1'b0, 50, 0);
            u0 = upd_cnt;
            run_phase($urandom_range(3, 25), 1'b1, 50, 2);
            checks++;
            if (upd_cnt - u0 > 1) begin
                failures++;
                $display("FAIL random_commits: got %0d updates in one blank required <=1",
                         upd_cnt - u0);
            end
        end
        run_phase(3, 1'b0, 0, 0);
        run_phase(30, 1'b1, 0, 0);
        checks++;
        if (sb.size() != 0 || level !== 5'd0) begin
            failures++;
            $display("FAIL random_final: got level=%0d left=%0d required 0 0", level, sb.size());
        end
    endtask

    initial begin
        checks = 0;
        failures = 0;
        en_cnt = 0;
        upd_cnt = 0;
        max_level = 0;
        test_reset();
        test_latency();
        test_overflow();
        test_partial_drain();
        test_back_to_back();
        test_one_commit_per_frame();
        test_reset_mid_drain();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: bench still running at %0t required completion", $time);
        $fatal(1, "timeout");
    end

endmodule

// File: doc/cell_update_queue.md
Name: cell_update_queue

Overview:
- Upstream feeder for matrix_display.
- Accepts asynchronous-in-time cell writes (x, y, rgb) from game/test logic into a small FIFO.
- Drains the FIFO into matrix_display's cell port (cell_rgb/cell_x/cell_y/cell_en) only during vertical blanking.
- Issues a single-cycle update pulse once per frame after a drain, so the visible grid never changes mid-scan.

Parameters:
- B_WIDTH, 5, bits of cell x index (GRID_WIDTH 20)
- B_HEIGHT, 4, bits of cell y index (GRID_HEIGHT 15)
- B_VGA, 4, bits per colour channel; rgb bus is 3*B_VGA
- B_S_HEIGHT, 10, bits of vcount
- S_HEIGHT, 768, first vcount value in vertical blank
- DEPTH, 16, FIFO entries; power of two
- B_DEPTH, 4, log2(DEPTH)

Ports:
- vclock  in  1  pixel clock (65 MHz); all logic on posedge
- reset  in  1  asynchronous, active-low reset
- wr_en  in  1  push request; accepted when wr_ready=1
- wr_x  in  B_WIDTH  cell column
- wr_y  in  B_HEIGHT  cell row
- wr_rgb  in  3*B_VGA  cell colour {r,g,b}
- wr_ready  out  1  FIFO not full
- vcount  in  B_S_HEIGHT  current VGA line from xvga
- cell_x  out  B_WIDTH  to matrix_display
- cell_y  out  B_HEIGHT  to matrix_display
- cell_rgb  out  3*B_VGA  to matrix_display
- cell_en  out  1  one-cycle strobe per cell write
- update  out  1  one-cycle commit pulse to matrix_display
- level  out  B_DEPTH+1  current FIFO occupancy 0..DEPTH
- overflow  out  1  sticky: a push was dropped

Behaviour:
- Reset (reset=0, asynchronous):
  - FIFO pointers and level go to 0; wr_ready=1.
  - cell_x, cell_y, cell_rgb, cell_en, update and overflow go to 0.
  - FSM goes to IDLE.
- in_blank = (vcount >= S_HEIGHT), combinational.
- Push:
  - Entry written when wr_en && wr_ready. level and wr_ready reflect it on the next edge.
  - wr_en while full: entry dropped, overflow<=1. overflow clears only on reset.
- Pop: one entry per cycle in DRAIN. Simultaneous push and pop is legal; level is unchanged. A full FIFO rejects a push even if a pop occurs that same cycle.
- FSM states: IDLE, DRAIN, COMMIT, HOLD.
  - IDLE: if in_blank && level!=0, go to DRAIN. Otherwise stay.
  - DRAIN: each cycle with level!=0 && in_blank, pop the head and register it onto cell_x/cell_y/cell_rgb with cell_en=1. Go to COMMIT when level==0 or in_blank falls, whichever comes first; that cycle's cell_en=0.
  - COMMIT: update=1 for exactly one cycle, then go to HOLD.
  - HOLD: wait until in_blank=0, then go to IDLE. This guarantees at most one commit per frame.
- Entries pushed during DRAIN are drained in the same blank if time remains.
- Latency:
  - An entry pushed during active video appears on cell_en on the 2nd cycle of the next blank interval (1 cycle to enter DRAIN, 1 registered).
  - update follows the last cell_en by 1 cycle.
- cell_* outputs hold their last value when cell_en=0.
- Wrap-around: read/write pointers are B_DEPTH bits and wrap naturally. level is computed separately and never exceeds DEPTH.
- Entering reset mid-DRAIN discards all queued entries; no update pulse is issued.

Optional Feature:
- Macro CELL_QUEUE_DROP_COUNT_EN.
- Defined: adds output port drop_count [7:0]. It counts rejected pushes, saturates at 255 and resets to 0.
- Undefined: the port and counter are absent; overflow remains the only drop indication.

Test Plan:
- Reset, then vcount=100, push (x=3,y=2,rgb=12'hF00) -> level=1, no cell_en. Step vcount to 768 -> cell_en=1 with x=3,y=2,rgb=F00 on the 2nd cycle of blank, update=1 the next cycle, level=0.
- Push 16 entries during active video -> wr_ready=0 after the 16th. A 17th push sets overflow=1 and level stays 16. With CELL_QUEUE_DROP_COUNT_EN, drop_count=1.
- Fill 16, enter blank, drop vcount to 0 after 5 cells drained -> exactly 5 cell_en pulses, one update, level=11. The next blank drains 11 more and gives one update.
- Push 1 entry per cycle throughout a blank that starts with 4 queued -> pushes and pops coexist, level stays at 4-ish until blank ends; every entry emerges in FIFO order with no loss.
- Blank with an empty FIFO -> no cell_en, no update. After a drain, vcount stays ≥768 with new pushes -> no second update until the next frame's blank.
- Assert reset=0 mid-DRAIN with 8 queued -> all outputs 0 immediately, level=0, no update; normal operation after release.
